// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encodings for the run/halt controller; the 7-segment display
// mux decodes the same values.
package cpu_run_ctrl_pkg;

    localparam logic [2:0] RC_HALT  = 3'd0;
    localparam logic [2:0] RC_RUN   = 3'd1;
    localparam logic [2:0] RC_STEP  = 3'd2;
    localparam logic [2:0] RC_BREAK = 3'd3;
    localparam logic [2:0] RC_DONE  = 3'd4;

endpackage

// File: rtl/cpu_run_ctrl_step_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each debounced rising edge. Reusable for any board push button.
module step_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK_CPU,
    input  logic RST_CPU,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            db      <= 1'b0;
            db_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            // synchronizer stage boundary: sync_p1 is the only safe view of btn_raw
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            db_q    <= db;
            if (sync_p1 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= sync_p1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign step_pulse = db & ~db_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step/breakpoint controller producing the MIPS core clock-enable,
// with a cycle budget that parks the core in DONE instead of ending simulation.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_CYCLES      = 512,
    parameter int CNT_W           = 32
) (
    input  logic             CLK_CPU,
    input  logic             RST_CPU,
    input  logic             run_req,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc_in,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic       step_pulse;
    logic       bp_match;
    logic       lim;
    logic [2:0] state_d;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .CLK_CPU    (CLK_CPU),
        .RST_CPU    (RST_CPU),
        .btn_raw    (step_btn),
        .step_pulse (step_pulse)
    );

    // Combinational compare so the instruction at bp_addr is held off before it executes
    assign bp_match = bp_en & (pc_in == bp_addr);
    assign lim      = (MAX_CYCLES != 0) && (cycle_cnt == CNT_W'(MAX_CYCLES));

    assign cpu_en = ((state == RC_RUN)  & ~bp_match & ~lim) |
                    ((state == RC_STEP) & ~lim);
    assign bp_hit = (state == RC_BREAK);

    always_comb begin
        state_d = state;
        case (state)
            RC_HALT: begin
                if (run_req)         state_d = RC_RUN;
                else if (step_pulse) state_d = RC_STEP;
            end
            RC_RUN: begin
                if (lim)             state_d = RC_DONE;
                else if (bp_match)   state_d = RC_BREAK;
                else if (!run_req)   state_d = RC_HALT;
            end
            RC_STEP: begin
                state_d = lim ? RC_DONE : RC_HALT;
            end
            RC_BREAK: begin
                if (step_pulse)      state_d = RC_STEP;
                else if (!run_req)   state_d = RC_HALT;
            end
            RC_DONE: begin
                state_d = RC_DONE;
            end
            default: begin
                state_d = RC_HALT;
            end
        endcase
    end

    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            state     <= RC_HALT;
            cycle_cnt <= '0;
        end else begin
            state <= state_d;
            // Saturate rather than wrap so an unlimited run never reports a small count
            if (cpu_en && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset, cycle budget, breakpoint, stepping
// past a breakpoint with a bouncing button, glitch rejection and priorities.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int DB   = 16;
    localparam int MAXC = 8;

    logic        CLK_CPU  = 1'b0;
    logic        RST_CPU  = 1'b1;
    logic        run_req  = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en    = 1'b0;
    logic [31:0] bp_addr  = 32'h0;
    logic [31:0] pc_in;
    logic        cpu_en;
    logic [2:0]  state;
    logic        bp_hit;
    logic [31:0] cycle_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_CYCLES     (MAXC),
        .CNT_W          (32)
    ) u_dut (
        .CLK_CPU   (CLK_CPU),
        .RST_CPU   (RST_CPU),
        .run_req   (run_req),
        .step_btn  (step_btn),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_in     (pc_in),
        .cpu_en    (cpu_en),
        .state     (state),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    // CPU PC model: advances one word per enabled cycle
    always @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU)     pc_in <= 32'h0;
        else if (cpu_en) pc_in <= pc_in + 32'd4;
    end

    task automatic do_reset();
        @(negedge CLK_CPU);
        run_req = 0; step_btn = 0; bp_en = 0; bp_addr = 32'h0;
        RST_CPU = 1;
        @(negedge CLK_CPU);
        RST_CPU = 0;
    endtask

    task automatic test_reset();
        do_reset();
        run_req = 1;
        repeat (3) @(negedge CLK_CPU);
        n_cmp++; if (cycle_cnt !== 32'd2) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 2", cycle_cnt); end
        #2 RST_CPU = 1;
        #1;
        n_cmp++; if (state !== RC_HALT) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, RC_HALT); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %0b expected 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_fail++; $display("FAIL reset_bp_hit: got %0b expected 0", bp_hit); end
        @(negedge CLK_CPU);
        RST_CPU = 0;
        @(negedge CLK_CPU);
        n_cmp++; if (state !== RC_RUN) begin n_fail++; $display("FAIL reset_release_run: got %0d expected %0d", state, RC_RUN); end
        n_cmp++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL reset_release_en: got %0b expected 1", cpu_en); end
    endtask

    task automatic test_budget();
        int en_cnt = 0;
        int bad = 0;
        do_reset();
        run_req = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK_CPU);
            if (cpu_en === 1'b1) en_cnt++;
            if (state === RC_DONE) break;
        end
        n_cmp++; if (en_cnt != MAXC) begin n_fail++; $display("FAIL budget_en_cycles: got %0d expected %0d", en_cnt, MAXC); end
        n_cmp++; if (state !== RC_DONE) begin n_fail++; $display("FAIL budget_state: got %0d expected %0d", state, RC_DONE); end
        n_cmp++; if (cycle_cnt !== 32'd8) begin n_fail++; $display("FAIL budget_cnt: got %0d expected 8", cycle_cnt); end
        for (int i = 0; i < 60; i++) begin
            step_btn = (i >= 5 && i < 45);
            run_req  = ((i / 4) % 2) == 0;
            @(negedge CLK_CPU);
            if (state !== RC_DONE || cpu_en !== 1'b0 || cycle_cnt !== 32'd8) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL budget_done_sticky: got %0d bad cycles expected 0", bad); end
        step_btn = 0;
    endtask

    task automatic test_breakpoint();
        int en_cnt = 0;
        do_reset();
        bp_en = 1; bp_addr = 32'h10; run_req = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK_CPU);
            if (cpu_en === 1'b1) en_cnt++;
            if (state === RC_BREAK) break;
        end
        n_cmp++; if (en_cnt != 4) begin n_fail++; $display("FAIL bp_en_cycles: got %0d expected 4", en_cnt); end
        n_cmp++; if (state !== RC_BREAK) begin n_fail++; $display("FAIL bp_state: got %0d expected %0d", state, RC_BREAK); end
        n_cmp++; if (bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_hit: got %0b expected 1", bp_hit); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL bp_cpu_en: got %0b expected 0", cpu_en); end
        n_cmp++; if (pc_in !== 32'h10) begin n_fail++; $display("FAIL bp_pc: got %0h expected 10", pc_in); end
        n_cmp++; if (cycle_cnt !== 32'd4) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 4", cycle_cnt); end
    endtask

    // Continues from the BREAK state left by test_breakpoint
    task automatic test_step_past_bp();
        int steps = 0, step_en = 0, step_idx = -1, saw_run = 0;
        logic [2:0]  prev = state;
        logic [2:0]  after_step = 3'd7;
        logic [31:0] pc_after = 32'hFFFF_FFFF;
        for (int i = 0; i < 80; i++) begin
            step_btn = (i < 12) ? ((i % 4) < 2) : (i < 52);
            @(negedge CLK_CPU);
            if (state === RC_STEP) begin
                steps++;
                if (cpu_en === 1'b1) step_en++;
                if (step_idx < 0) step_idx = i;
            end
            if (prev === RC_STEP) begin after_step = state; pc_after = pc_in; end
            if (prev === RC_HALT && state === RC_RUN && steps > 0) saw_run = 1;
            prev = state;
        end
        step_btn = 0;
        n_cmp++; if (steps != 1) begin n_fail++; $display("FAIL step_count: got %0d expected 1", steps); end
        n_cmp++; if (step_en != 1) begin n_fail++; $display("FAIL step_en_cycles: got %0d expected 1", step_en); end
        n_cmp++; if (step_idx < 12 + DB + 2 || step_idx > 12 + DB + 4) begin n_fail++; $display("FAIL step_latency: got %0d expected %0d..%0d", step_idx, 12 + DB + 2, 12 + DB + 4); end
        n_cmp++; if (after_step !== RC_HALT) begin n_fail++; $display("FAIL step_then_halt: got %0d expected %0d", after_step, RC_HALT); end
        n_cmp++; if (pc_after !== 32'h14) begin n_fail++; $display("FAIL step_pc: got %0h expected 14", pc_after); end
        n_cmp++; if (saw_run != 1) begin n_fail++; $display("FAIL step_resume_run: got %0d expected 1", saw_run); end
        n_cmp++; if (state !== RC_DONE) begin n_fail++; $display("FAIL step_final_state: got %0d expected %0d", state, RC_DONE); end
        n_cmp++; if (pc_in !== 32'h20) begin n_fail++; $display("FAIL step_final_pc: got %0h expected 20", pc_in); end
        n_cmp++; if (cycle_cnt !== 32'd8) begin n_fail++; $display("FAIL step_final_cnt: got %0d expected 8", cycle_cnt); end
    endtask

    task automatic test_glitch();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step_btn = (i < 10);
            @(negedge CLK_CPU);
            if (state !== RC_HALT || cpu_en !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL glitch_no_step: got %0d bad cycles expected 0", bad); end
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL glitch_cnt: got %0d expected 0", cycle_cnt); end
    endtask

    task automatic test_simultaneous();
        int found = 0, lat = -1, bad = 0;
        do_reset();
        step_btn = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_CPU);
            if (u_dut.u_step.step_pulse === 1'b1) begin found = 1; lat = i + 1; break; end
        end
        n_cmp++; if (found != 1) begin n_fail++; $display("FAIL sim_pulse_seen: got %0d expected 1", found); end
        n_cmp++; if (lat < DB + 2 || lat > DB + 4) begin n_fail++; $display("FAIL sim_pulse_latency: got %0d expected %0d..%0d", lat, DB + 2, DB + 4); end
        n_cmp++; if (state !== RC_HALT) begin n_fail++; $display("FAIL sim_pre_state: got %0d expected %0d", state, RC_HALT); end
        run_req = 1;
        @(negedge CLK_CPU);
        n_cmp++; if (state !== RC_RUN) begin n_fail++; $display("FAIL sim_run_wins: got %0d expected %0d", state, RC_RUN); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_CPU);
            if (state === RC_STEP) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL sim_no_step: got %0d step cycles expected 0", bad); end
        step_btn = 0;

        do_reset();
        bp_en = 1; bp_addr = 32'h8; run_req = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_CPU);
            if (state === RC_RUN && pc_in === 32'h8) begin found = 1; break; end
        end
        n_cmp++; if (found != 1) begin n_fail++; $display("FAIL prio_reach_bp: got %0d expected 1", found); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL prio_bp_gate: got %0b expected 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== 32'd2) begin n_fail++; $display("FAIL prio_cnt: got %0d expected 2", cycle_cnt); end
        run_req = 0;
        @(negedge CLK_CPU);
        n_cmp++; if (state !== RC_BREAK) begin n_fail++; $display("FAIL prio_break_over_halt: got %0d expected %0d", state, RC_BREAK); end
        n_cmp++; if (bp_hit !== 1'b1) begin n_fail++; $display("FAIL prio_bp_hit: got %0b expected 1", bp_hit); end
        @(negedge CLK_CPU);
        n_cmp++; if (state !== RC_HALT) begin n_fail++; $display("FAIL prio_break_to_halt: got %0d expected %0d", state, RC_HALT); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_fail++; $display("FAIL prio_bp_hit_clear: got %0b expected 0", bp_hit); end
    endtask

    initial begin
        test_reset();
        test_budget();
        test_breakpoint();
        test_step_past_bp();
        test_glitch();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
